ed25519_op_ctrl: RTL

ED25519_OP_CTRL -- requirements
Module: ed25519_op_ctrl

---
 rtl/ed25519_op_ctrl.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ed25519_op_ctrl.sv
// Ed25519 operation controller: sequences one keygen/sign/verify command through
// an external engine, writes results to the key register file and returns a response.
module ed25519_op_ctrl #(
    parameter int KEY_W     = 256,
    parameter int SIG_W     = 512,
    parameter int TO_CYCLES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_opmode,
    output logic             eng_start,
    output logic [1:0]       eng_opmode,
    input  logic             eng_done,
    input  logic [SIG_W-1:0] eng_data,
    input  logic [KEY_W-1:0] eng_pubkey,
    input  logic             eng_verify_ok,
    output logic             rf_we,
    output logic [2:0]       rf_addr,
    output logic [SIG_W-1:0] rf_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_status,
    output logic [1:0]       rsp_opmode,
    output logic [KEY_W-1:0] rsp_pubkey,
    output logic [SIG_W-1:0] rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] ok_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_WB1    = 3'd3;
    localparam logic [2:0] S_WB2    = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    localparam logic [1:0] OP_KEYGEN  = 2'b00;
    localparam logic [1:0] OP_SIGN    = 2'b01;
    localparam logic [1:0] OP_VERIFY  = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_VFAIL   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    localparam logic [2:0] ADDR_PRIV  = 3'b011;
    localparam logic [2:0] ADDR_PUB   = 3'b100;
    localparam logic [2:0] ADDR_SIG   = 3'b110;

    localparam int              TO_W    = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    logic [2:0]       state_r;
    logic [2:0]       state_s;
    logic [1:0]       op_r;
    logic [1:0]       op_s;
    logic [1:0]       status_s;
    logic [TO_W-1:0]  to_cnt_r;
    logic [SIG_W-1:0] cap_data_r;
    logic [KEY_W-1:0] cap_pubkey_r;

    logic             cmd_ready_r;
    logic             busy_r;
    logic             eng_start_r;
    logic [1:0]       eng_opmode_r;
    logic             rf_we_r;
    logic [2:0]       rf_addr_r;
    logic [SIG_W-1:0] rf_wdata_r;
    logic             rsp_valid_r;
    logic [1:0]       rsp_status_r;
    logic [1:0]       rsp_opmode_r;
    logic [KEY_W-1:0] rsp_pubkey_r;
    logic [SIG_W-1:0] rsp_data_r;
    logic [CNT_W-1:0] ok_count_r;

    logic [SIG_W-1:0] rf_wdata_s;
    logic [2:0]       rf_addr_s;
    logic [SIG_W-1:0] rsp_data_s;
    logic [KEY_W-1:0] rsp_pubkey_s;

    // Next-state, latched opmode and response status selection
    always_comb begin
        state_s  = state_r;
        op_s     = op_r;
        status_s = ST_OK;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_s = cmd_opmode;
                    if (cmd_opmode == OP_ILLEGAL) begin
                        state_s  = S_RESP;
                        status_s = ST_ILLEGAL;
                    end else begin
                        state_s = S_LAUNCH;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LAUNCH: begin
                state_s = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the final count still wins over the timeout
                if (eng_done) begin
                    case (op_r)
                        OP_KEYGEN: state_s = S_WB1;
                        OP_SIGN:   state_s = S_WB1;
                        OP_VERIFY: begin
                            state_s  = S_RESP;
                            status_s = eng_verify_ok ? ST_OK : ST_VFAIL;
                        end
                        default: begin
                            state_s  = S_RESP;
                            status_s = ST_ILLEGAL;
                        end
                    endcase
                end else if (to_cnt_r == TO_LAST) begin
                    state_s  = S_RESP;
                    status_s = ST_TIMEOUT;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_WB1: begin
                if (op_r == OP_KEYGEN) begin
                    state_s = S_WB2;
                end else begin
                    state_s = S_RESP;
                end
            end
            S_WB2: begin
                state_s = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_RESP;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Register-file write payload for the state being entered
    always_comb begin
        rf_wdata_s = {SIG_W{1'b0}};
        rf_addr_s  = 3'b000;
        if (state_s == S_WB1) begin
            // Entered from WAIT, so the engine data is still on the bus this cycle
            rf_wdata_s = eng_data;
            rf_addr_s  = (op_s == OP_KEYGEN) ? ADDR_PRIV : ADDR_SIG;
        end else if (state_s == S_WB2) begin
            rf_wdata_s = {{(SIG_W-KEY_W){1'b0}}, cap_pubkey_r};
            rf_addr_s  = ADDR_PUB;
        end else begin
            rf_wdata_s = {SIG_W{1'b0}};
            rf_addr_s  = 3'b000;
        end
    end

    // Response payload: data only after a write-back, pubkey only after keygen
    always_comb begin
        rsp_data_s   = {SIG_W{1'b0}};
        rsp_pubkey_s = {KEY_W{1'b0}};
        if (state_r == S_WB1 || state_r == S_WB2) begin
            rsp_data_s = cap_data_r;
        end else begin
            rsp_data_s = {SIG_W{1'b0}};
        end
        if (state_r == S_WB2) begin
            rsp_pubkey_s = cap_pubkey_r;
        end else begin
            rsp_pubkey_s = {KEY_W{1'b0}};
        end
    end

    // State, latched opmode and timeout counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= S_IDLE;
            op_r     <= 2'b00;
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            state_r <= state_s;
            op_r    <= op_s;
            if (state_r == S_LAUNCH) begin
                to_cnt_r <= {TO_W{1'b0}};
            end else if (state_r == S_WAIT) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= to_cnt_r;
            end
        end
    end

    // Engine result capture, cleared at launch so a timeout reports zeros
    always_ff @(posedge clk) begin
        if (!rst) begin
            cap_data_r   <= {SIG_W{1'b0}};
            cap_pubkey_r <= {KEY_W{1'b0}};
        end else if (state_r == S_LAUNCH) begin
            cap_data_r   <= {SIG_W{1'b0}};
            cap_pubkey_r <= {KEY_W{1'b0}};
        end else if (state_r == S_WAIT && eng_done) begin
            cap_data_r   <= eng_data;
            cap_pubkey_r <= eng_pubkey;
        end else begin
            cap_data_r   <= cap_data_r;
            cap_pubkey_r <= cap_pubkey_r;
        end
    end

    // Handshake, engine and register-file outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            eng_start_r  <= 1'b0;
            eng_opmode_r <= 2'b00;
            rf_we_r      <= 1'b0;
            rf_addr_r    <= 3'b000;
            rf_wdata_r   <= {SIG_W{1'b0}};
        end else begin
            cmd_ready_r  <= (state_s == S_IDLE);
            busy_r       <= (state_s != S_IDLE);
            eng_start_r  <= (state_s == S_LAUNCH);
            eng_opmode_r <= (state_s == S_LAUNCH || state_s == S_WAIT) ? op_s : 2'b00;
            rf_we_r      <= (state_s == S_WB1 || state_s == S_WB2);
            rf_addr_r    <= rf_addr_s;
            rf_wdata_r   <= rf_wdata_s;
        end
    end

    // Response registers: loaded on RESP entry, held until handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_r  <= 1'b0;
            rsp_status_r <= 2'b00;
            rsp_opmode_r <= 2'b00;
            rsp_data_r   <= {SIG_W{1'b0}};
            rsp_pubkey_r <= {KEY_W{1'b0}};
        end else if (state_s == S_RESP && state_r != S_RESP) begin
            rsp_valid_r  <= 1'b1;
            rsp_status_r <= status_s;
            rsp_opmode_r <= op_s;
            rsp_data_r   <= rsp_data_s;
            rsp_pubkey_r <= rsp_pubkey_s;
        end else if (state_s == S_RESP) begin
            rsp_valid_r  <= rsp_valid_r;
            rsp_status_r <= rsp_status_r;
            rsp_opmode_r <= rsp_opmode_r;
            rsp_data_r   <= rsp_data_r;
            rsp_pubkey_r <= rsp_pubkey_r;
        end else begin
            rsp_valid_r  <= 1'b0;
            rsp_status_r <= 2'b00;
            rsp_opmode_r <= 2'b00;
            rsp_data_r   <= {SIG_W{1'b0}};
            rsp_pubkey_r <= {KEY_W{1'b0}};
        end
    end

    // Successful-operation counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            ok_count_r <= {CNT_W{1'b0}};
        end else if (rsp_valid_r && rsp_ready && rsp_status_r == ST_OK) begin
            ok_count_r <= ok_count_r + CNT_W'(1);
        end else begin
            ok_count_r <= ok_count_r;
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign busy       = busy_r;
    assign eng_start  = eng_start_r;
    assign eng_opmode = eng_opmode_r;
    assign rf_we      = rf_we_r;
    assign rf_addr    = rf_addr_r;
    assign rf_wdata   = rf_wdata_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_status = rsp_status_r;
    assign rsp_opmode = rsp_opmode_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_pubkey = rsp_pubkey_r;
    assign ok_count   = ok_count_r;

endmodule
